div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider in the EX stage, serving MIPS DIV/DIVU.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Drives stallreq_for_ex into the stall controller, which holds IF/ID/EX/MEM until the result is ready.
- Result is written back to HI/LO as {remainder, quotient}.

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit.sv | 123 ++++++++++++
 tb/tb_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage radix-2 restoring divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit: one restoring quotient bit per cycle, result {rem, quo}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic                  start,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_for_ex
);

  localparam int CW = $clog2(DATA_W);

  div_state_e          r_state;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_dvd;   // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]   r_dvs;
  logic [DATA_W-1:0]   r_rem;
  logic                r_qneg;
  logic                r_rneg;
  logic [2*DATA_W-1:0] r_result;
  logic                r_ready;

  logic [DATA_W:0]     w_shift;
  logic [DATA_W+1:0]   w_diff;
  logic                w_ge;
  logic [DATA_W-1:0]   w_rem_nx;
  logic [DATA_W-1:0]   w_quo_nx;
  logic [DATA_W-1:0]   w_q_fix;
  logic [DATA_W-1:0]   w_r_fix;
  logic [DATA_W-1:0]   w_a_abs;
  logic [DATA_W-1:0]   w_b_abs;

  always_comb begin
    w_shift  = {r_rem, r_dvd[DATA_W-1]};
    w_diff   = {1'b0, w_shift} - {2'b00, r_dvs};
    w_ge     = ~w_diff[DATA_W+1];
    w_rem_nx = w_ge ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    w_quo_nx = {r_dvd[DATA_W-2:0], w_ge};
    w_q_fix  = r_qneg ? -w_quo_nx : w_quo_nx;
    w_r_fix  = r_rneg ? -w_rem_nx : w_rem_nx;
    w_a_abs  = (signed_div && op_a[DATA_W-1]) ? -op_a : op_a;
    w_b_abs  = (signed_div && op_b[DATA_W-1]) ? -op_b : op_b;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start == DivStart && !annul) begin
            if (op_b == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state <= DivOn;
              r_dvd   <= w_a_abs;
              r_dvs   <= w_b_abs;
              r_rem   <= '0;
              r_qneg  <= signed_div & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
              r_rneg  <= signed_div & op_a[DATA_W-1];
              r_cnt   <= '0;
            end
          end
        end
        DivByZero: begin
          if (annul) begin
            r_state <= DivFree;
          end else begin
            r_state  <= DivEnd;
            r_result <= '0;
            r_ready  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul) begin
            r_state <= DivFree;
          end else begin
            r_dvd <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(DATA_W-1)) begin
              r_result <= {w_r_fix, w_q_fix};
              r_ready  <= DivResultReady;
              r_state  <= DivEnd;
            end
          end
        end
        DivEnd: begin
          if (annul) begin
            r_state <= DivFree;
            r_ready <= DivResultNotReady;
          end else if (start == DivStop) begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

  assign result          = r_result;
  assign ready           = r_ready;
  assign stallreq_for_ex = start & ~r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed + random checks of div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .signed_div      (signed_div),
    .op_a            (op_a),
    .op_b            (op_b),
    .start           (start),
    .annul           (annul),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  // MIPS semantics: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q;
    logic [31:0] r;
    int sa;
    int sb;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide, counts cycles to ready, checks result, hold, and release.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int lat, input bit scramble);
    logic [63:0] exp;
    int          n;
    bit          seen;
    exp        = ref_div(a, b, s);
    op_a       = a;
    op_b       = b;
    signed_div = s;
    start      = 1'b1;
    #1 chk("stall_at_start", 64'(stallreq_for_ex), 64'(1));
    n    = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      tick();
      n++;
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      if (ready) seen = 1'b1;
      else chk("stall_busy", 64'(stallreq_for_ex), 64'(1));
    end
    chk("latency", 64'(n), 64'(lat));
    chk("result", result, exp);
    chk("stall_ready", 64'(stallreq_for_ex), 64'(0));
    tick();
    chk("hold_ready", 64'(ready), 64'(1));
    chk("hold_result", result, exp);
    start = 1'b0;
    tick();
    chk("drop_ready", 64'(ready), 64'(0));
    chk("drop_result", result, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          seen;

    resetn     = 1'b0;
    start      = 1'b0;
    annul      = 1'b0;
    signed_div = 1'b0;
    op_a       = '0;
    op_b       = '0;
    repeat (3) tick();
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'(0));
    chk("reset_stall", 64'(stallreq_for_ex), 64'(0));
    resetn = 1'b1;
    tick();

    run_div(32'd100, 32'd7, 1'b0, 33, 1'b0);
    chk("divu_100_7_lit", {32'd2, 32'd14}, ref_div(32'd100, 32'd7, 1'b0));
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 1'b0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 33, 1'b1);
    run_div(32'd1234, 32'd0, 1'b1, 2, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 1'b0);

    // Annul after 10 ON cycles: nothing may complete.
    op_a = 32'd1000; op_b = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (11) tick();
    annul = 1'b1;
    start = 1'b0;
    tick();
    chk("annul_ready", 64'(ready), 64'(0));
    annul = 1'b0;
    seen  = 1'b0;
    repeat (40) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("annul_never_ready", 64'(seen), 64'(0));
    run_div(32'd200, 32'd10, 1'b0, 33, 1'b0);

    // Start and annul together in IDLE: annul wins.
    op_a = 32'd50; op_b = 32'd5; start = 1'b1; annul = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready) seen = 1'b1;
    end
    chk("start_annul_idle", 64'(seen), 64'(0));
    start = 1'b0; annul = 1'b0;
    tick();

    // Reset during ON, then a clean divide.
    op_a = 32'd999; op_b = 32'd4; start = 1'b1;
    repeat (6) tick();
    resetn = 1'b0;
    start  = 1'b0;
    tick();
    chk("rst_on_ready", 64'(ready), 64'(0));
    chk("rst_on_result", result, 64'd0);
    chk("rst_on_stall", 64'(stallreq_for_ex), 64'(0));
    resetn = 1'b1;
    tick();
    run_div(32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 33, 1'b0);

    // Reset while END holds a non-zero result.
    op_a = 32'd77; op_b = 32'd5; start = 1'b1;
    repeat (35) tick();
    chk("pre_rst_end", result, ref_div(32'd77, 32'd5, 1'b0));
    resetn = 1'b0;
    tick();
    chk("rst_end_result", result, 64'd0);
    chk("rst_end_ready", 64'(ready), 64'(0));
    start  = 1'b0;
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 17));
        default: rb = $urandom;
      endcase
      if (i == 5) ra = 32'h8000_0000;
      run_div(ra, rb, 1'($urandom_range(0, 1)), (rb == 32'd0) ? 2 : 33, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
